frame_flip_scanout: RTL and testbench

- Display-side partner of the renderer's vsync/flip interface.
- Generates raster scan timing (hsync, vsync, de, pixel x/y) and feeds vsync back to the renderer.
- Owns the double-buffer index: accepts the renderer's flip request and swaps front/back buffer only at the start of vertical blank, so scanout never tears.
- Sits between the renderer and the video output / framebuffer read path.

---
 rtl/display_pkg.sv | 19 +
 rtl/scan_timing_gen.sv | 82 ++++++++
 rtl/frame_flip_scanout.sv | 97 +++++++++
 tb/tb_frame_flip_scanout.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared display timing defaults and types for the scanout path.
package display_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CW       = 11;

  typedef enum logic [1:0] {IDLE, PENDING, SWAP} flip_state_e;

  typedef struct packed {
    logic [DEF_CW-1:0] x;
    logic [DEF_CW-1:0] y;
  } scan_pos_t;
endpackage

// File: rtl/scan_timing_gen.sv
// Raster counters with registered sync/blank decode and a swap-point strobe.
module scan_timing_gen
  import display_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_ce,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          vblank,
  output logic          swap_point
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_SWAP   = CW'(V_ACTIVE - 1);

  function automatic logic sync_lvl(input logic active);
    return active ? SYNC_POL : ~SYNC_POL;
  endfunction

  logic [CW-1:0] x_p0;
  logic [CW-1:0] y_p0;

  // Stage p0: next raster position
  always_comb begin
    x_p0 = x;
    y_p0 = y;
    if (pix_ce) begin
      if (x == H_LAST) begin
        x_p0 = '0;
        y_p0 = (y == V_LAST) ? '0 : y + 1'b1;
      end else begin
        x_p0 = x + 1'b1;
      end
    end
  end

  // Stage p1: position and its decode registered together so they stay aligned
  always_ff @(posedge clk) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      hsync  <= sync_lvl(1'b0);
      vsync  <= sync_lvl(1'b0);
      de     <= 1'b1;
      vblank <= 1'b0;
    end else begin
      x      <= x_p0;
      y      <= y_p0;
      hsync  <= sync_lvl((x_p0 >= HS_START) && (x_p0 < HS_END));
      vsync  <= sync_lvl((y_p0 >= VS_START) && (y_p0 < VS_END));
      de     <= (x_p0 < H_ACT) && (y_p0 < V_ACT);
      vblank <= (y_p0 >= V_ACT);
    end
  end

  // Last pixel of the last active line, only when the pixel actually advances
  assign swap_point = pix_ce && (x == H_LAST) && (y == V_SWAP);
endmodule

// File: rtl/frame_flip_scanout.sv
// Scanout timing plus tear-free front/back buffer swap at the start of vblank.
// Optional FRAME_FLIP_STATS_EN adds a saturating missed_frames counter.
module frame_flip_scanout
  import display_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_ce,
  input  logic          flip,
  output logic          hsync,
  output logic          vsync,
  output logic          vblank,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          front_buf,
  output logic          flip_ack
`ifdef FRAME_FLIP_STATS_EN
  ,
  output logic [15:0]   missed_frames
`endif
);
  logic        swap_point;
  logic        flip_q;
  logic        flip_rise;
  flip_state_e state;
  flip_state_e state_nxt;

  scan_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL), .CW(CW)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .pix_ce     (pix_ce),
    .x          (x),
    .y          (y),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .vblank     (vblank),
    .swap_point (swap_point)
  );

  assign flip_rise = flip && !flip_q;

  // A request arriving on the swap point itself is taken in this frame
  always_comb begin
    state_nxt = state;
    flip_ack  = (state == SWAP);
    case (state)
      IDLE:    if (flip_rise) state_nxt = swap_point ? SWAP : PENDING;
      PENDING: if (swap_point) state_nxt = SWAP;
      SWAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flip_q    <= 1'b0;
      state     <= IDLE;
      front_buf <= 1'b0;
    end else begin
      flip_q    <= flip;
      state     <= state_nxt;
      front_buf <= front_buf ^ (state_nxt == SWAP);
    end
  end

`ifdef FRAME_FLIP_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A frame boundary passed with no request outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      missed_frames <= '0;
    end else if ((state == IDLE) && swap_point && !flip_rise) begin
      missed_frames <= sat_inc(missed_frames);
    end
  end
`endif
endmodule

// File: tb/tb_frame_flip_scanout.sv
// Scoreboard bench for frame_flip_scanout on a 14x7 raster (8x4 active).
module tb_frame_flip_scanout;
  logic        clk = 1'b0;
  logic        reset;
  logic        pix_ce;
  logic        flip;
  logic        hsync, vsync, vblank, de, front_buf, flip_ack;
  logic [10:0] x, y;
`ifdef FRAME_FLIP_STATS_EN
  logic [15:0] missed_frames;
`endif

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  typedef struct {
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic de;
    logic vb;
    logic fb;
    logic ack;
  } exp_t;

  exp_t exp_q[$];

  frame_flip_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .CW(11)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_ce    (pix_ce),
    .flip      (flip),
    .hsync     (hsync),
    .vsync     (vsync),
    .vblank    (vblank),
    .de        (de),
    .x         (x),
    .y         (y),
    .front_buf (front_buf),
    .flip_ack  (flip_ack)
`ifdef FRAME_FLIP_STATS_EN
    ,
    .missed_frames (missed_frames)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, req, $time);
    end
  endtask

  // Expected outputs for raster position p (0..97) of the 14x7 frame
  task automatic push_exp(input int p, input logic fb, input logic ack);
    exp_t e;
    e.x   = p % 14;
    e.y   = p / 14;
    e.hs  = !(e.x == 10 || e.x == 11);
    e.vs  = !(e.y == 5);
    e.de  = (e.x < 8) && (e.y < 4);
    e.vb  = (e.y >= 4);
    e.fb  = fb;
    e.ack = ack;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("x", int'(x), e.x);
          chk("y", int'(y), e.y);
          chk("hsync", int'(hsync), int'(e.hs));
          chk("vsync", int'(vsync), int'(e.vs));
          chk("de", int'(de), int'(e.de));
          chk("vblank", int'(vblank), int'(e.vb));
          chk("front_buf", int'(front_buf), int'(e.fb));
          chk("flip_ack", int'(flip_ack), int'(e.ack));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int   p;
    logic fb_e;
    logic ack;
    reset  = 1'b1;
    pix_ce = 1'b1;
    flip   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Frames 0..8 back to back: sweep, then flips in active, in blank,
    // held high, doubled, on the swap point, and one cut short by reset
    fb_e = 1'b0;
    for (int g = 0; g <= 812; g++) begin
      flip = (g == 115) || (g >= 254 && g <= 256) || (g >= 402 && g < 560) ||
             (g == 603) || (g == 618) || (g == 741) || (g == 801);
      pix_ce = 1'b1;
      reset  = (g == 812);
      ack = (g == 154) || (g == 350) || (g == 448) || (g == 644) || (g == 742);
      if (ack) fb_e = ~fb_e;
      push_exp(g % 98, fb_e, ack);
      @(posedge clk);
      #1;
    end

    // After reset: discarded request, then a swap delayed by pix_ce stalls
    p    = 0;
    fb_e = 1'b0;
    for (int k = 0; k <= 294; k++) begin
      reset  = 1'b0;
      flip   = (k == 115);
      pix_ce = !(k >= 153 && k <= 155);
      ack    = (k == 157);
      if (ack) fb_e = 1'b1;
      push_exp(p, fb_e, ack);
      if (pix_ce) p = (p + 1) % 98;
      @(posedge clk);
      #1;
    end
    mon_en = 1'b0;

`ifdef FRAME_FLIP_STATS_EN
    chk("missed_frames", int'(missed_frames), 2);
`endif
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
